dm_port_arbiter: RTL
====================

# dm_port_arbiter

Sequencing and arbitration controller for the word-wide data memory. Shares one single-port, word-write-only synchronous SRAM between the CPU M stage and a DMA/loader requester. Performs read-modify-write for half-word and byte stores, so the memory array itself never needs sub-word write logic. Sits between the M-stage store/load path and the DM array.

## Interface
Parameters:
- ADDR_W, 12, word-address width of the memory (4096 words)

Ports, with the CPU requester as prefix c_ and the DMA requester as prefix d_:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous, active-low reset
- c_req / d_req  in  1  request; held with all fields stable until ack
- c_size / d_size  in  2  access type: 0 load, 1 word store, 2 half store, 3 byte store
- c_addr / d_addr  in  32  byte address
- c_wdata / d_wdata  in  32  store data; sub-word data in the low bits
- c_ack / d_ack  out  1  one-cycle completion pulse
- c_err / d_err  out  1  misaligned half store; valid only with ack
- c_rdata / d_rdata  out  32  full load word; valid only with ack on a load
- m_en  out  1  memory strobe
- m_we  out  1  memory write, qualified by m_en
- m_addr  out  ADDR_W  word address, equal to addr[ADDR_W+1:2]
- m_wdata  out  32  write word
- m_rdata  in  32  read word, valid the cycle after m_en with m_we=0

## Operation
- States: IDLE, RD, WAIT, WR, ERR.
- Requests are sampled only in IDLE.
  - The granted request's size, addr and wdata are latched.
  - The last_gnt register is updated.
- Arbitration is round-robin. If both requesters are active, the one that is not last_gnt wins. A single requester always wins. last_gnt resets to DMA, so the CPU wins the first contest.
- Transitions out of IDLE:
  - Load, half store or byte store goes to RD.
  - Word store goes to WR.
  - Half store with addr[0]=1 goes to ERR.
- Word accesses ignore addr[1:0]. They never raise err.
- RD: drive m_en=1 and m_we=0, then go to WAIT.
- WAIT: m_rdata is valid.
  - Load: assert ack with rdata=m_rdata, then go to IDLE.
  - Sub-word store: latch the merged word, then go to WR.
- Merge rules:
  - Half store: addr[1]=0 replaces bits [15:0]; addr[1]=1 replaces bits [31:16]; data comes from wdata[15:0].
  - Byte store: lane addr[1:0] replaces bits [8k+7:8k]; data comes from wdata[7:0].
- WR: drive m_en=1 and m_we=1. m_wdata is wdata for a word store, or the merged word otherwise. Assert ack, then go to IDLE.
- ERR: assert ack and err with no memory strobe, then go to IDLE.
- ack, err and rdata are driven only to the granted requester. The other requester sees 0.
- m_addr and m_wdata are don't-care when m_en=0, but are driven from the latched request.

## Timing
Request sampled in IDLE at cycle T. Completion times:
- Word store: WR at T+1, ack at T+1.
- Load: RD at T+1, WAIT at T+2, ack at T+2.
- Sub-word store: RD at T+1, WAIT at T+2, WR at T+3, ack at T+3.
- Error: ack and err at T+1.

Rules:
- ack, err and rdata are combinational from state and registers. rdata is combinational from m_rdata.
- The state after ack is always IDLE. A requester that keeps req high in the cycle after ack is treated as issuing a new request.
- A request arriving while the FSM is busy waits. There is no queue and no timeout.
- The DM array is owned exclusively by this block, so no other writer can hit the word between RD and WR.
- Reset values: state=IDLE, last_gnt=DMA, latched fields=0. All outputs are 0 (m_en, m_we, acks, errs, rdata bus, m_addr, m_wdata).
- Reset mid-operation forces IDLE immediately.
  - An RMW interrupted before WR leaves memory unchanged.
  - No ack is issued for the abandoned request.

## Structure
- Package dm_arb_pkg holds:
  - the state enum;
  - the size codes SZ_LOAD=0, SZ_WORD=1, SZ_HALF=2, SZ_BYTE=3;
  - the requester IDs CPU=0 and DMA=1.
- One sub-module: store_merge, purely combinational, taking (old word, wdata, size, addr[1:0]) and returning the merged word. It is shared by the WAIT latch path and by the verification model.

## Test plan
- CPU word store, addr 0x10, data 0xDEADBEEF:
  - m_en=1, m_we=1, m_addr=4 at T+1, ack at T+1;
  - a following load at 0x10 returns 0xDEADBEEF at T+2.
- Byte store, addr 0x13, data 0x000000AB, over word 0x11223344: memory becomes 0xAB223344, ack at T+3, exactly one write strobe.
- Half store, addr 0x12, data 0x00005566, over 0x11223344: memory becomes 0x55663344. Half store at addr 0x10 over the result gives 0x55665566.
- Both requesters held high from reset, each issuing word stores: grants are CPU, DMA, CPU, DMA. The non-granted ack and rdata stay 0.
- Half store at addr 0x11: ack and err at T+1, m_en never asserted, memory unchanged.
- clr_n pulsed low while in WAIT of a byte store: all outputs 0 immediately, target word unchanged. The next word store completes normally at T+1.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and codes for the data-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_arb_pkg;

    // Sequencer states; one access is in flight at a time.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Access size codes as presented on the requester ports.
    localparam logic [1:0] SZ_LOAD = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_BYTE = 2'd3;

    // Requester identities, as stored in the last-grant register.
    localparam logic CPU = 1'b0;
    localparam logic DMA = 1'b1;

    // First state after a grant: word stores skip the read, odd half
    // stores are rejected, everything else reads the word first.
    function automatic state_t entry_state(input logic [1:0] size, input logic addr_b0);
        state_t st;
        st = RD;
        if (size == SZ_WORD) begin
            st = WR;
        end else if ((size == SZ_HALF) && addr_b0) begin
            st = ERR;
        end
        return st;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundles both requester ports and the SRAM port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req and fields stable until their ack pulse.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    // CPU requester
    logic              c_req;
    logic [1:0]        c_size;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic              c_ack;
    logic              c_err;
    logic [31:0]       c_rdata;

    // DMA / loader requester
    logic              d_req;
    logic [1:0]        d_size;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [31:0]       d_rdata;

    // Single-port word-wide SRAM
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    // Requesters and the memory array: drive requests and read data.
    modport master (
        output c_req, c_size, c_addr, c_wdata,
        input  c_ack, c_err, c_rdata,
        output d_req, d_size, d_addr, d_wdata,
        input  d_ack, d_err, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

    // The arbiter itself.
    modport slave (
        input  c_req, c_size, c_addr, c_wdata,
        output c_ack, c_err, c_rdata,
        input  d_req, d_size, d_addr, d_wdata,
        output d_ack, d_err, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

endinterface

// File: rtl/dm_port_arbiter_store_merge.sv
// Merges sub-word store data into the word read back from memory.
// Latency: purely combinational.
// Backpressure: none.
module store_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);
    import dm_arb_pkg::*;

    // Replace only the addressed half or byte lane; loads pass the old word through.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_WORD: merged = wdata;
            SZ_HALF: begin
                if (lane[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin CPU/DMA arbiter for one word-write SRAM port, doing RMW for half/byte stores.
// Latency: word store or misaligned half 1 cycle, load 2, half/byte store 3 after the grant cycle.
// Backpressure: requests are only sampled in IDLE; a requester waits with req held until its ack.
module dm_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic             clk,
    input  logic             clr_n,
    dm_port_arbiter_if.slave bus
);
    import dm_arb_pkg::*;

    // Registered state and the latched request
    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merged_q, merged_d;

    // Arbitration result for the current IDLE cycle
    logic              gnt;
    logic [1:0]        req_size;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;

    logic [31:0]       merge_word;
    logic              ack;
    logic              err;
    logic              rdata_vld;

    // Byte address bits above the memory size are ignored by design.
    logic              addr_hi_unused;
    assign addr_hi_unused = ^{bus.c_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2]};

    // Round-robin pick: on contention the requester that did not win last time goes next
    always_comb begin
        if (bus.c_req && bus.d_req) begin
            gnt = ~last_gnt_q;
        end else if (bus.c_req) begin
            gnt = CPU;
        end else begin
            gnt = DMA;
        end
        req_size  = (gnt == CPU) ? bus.c_size               : bus.d_size;
        req_addr  = (gnt == CPU) ? bus.c_addr[ADDR_W+1:0]   : bus.d_addr[ADDR_W+1:0];
        req_wdata = (gnt == CPU) ? bus.c_wdata              : bus.d_wdata;
    end

    // Old word from the read cycle merged with the latched sub-word data
    store_merge u_store_merge (
        .old_word (bus.m_rdata),
        .wdata    (wdata_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .merged   (merge_word)
    );

    // Sequencer: grant and latch in IDLE, then walk the read / write steps
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merged_d   = merged_q;
        case (state_q)
            IDLE: begin
                if (bus.c_req || bus.d_req) begin
                    last_gnt_d = gnt;
                    size_d     = req_size;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    state_d    = entry_state(req_size, req_addr[0]);
                end
            end
            RD: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Memory read data is valid here; stores capture the merged word
                // so the write cycle does not depend on m_rdata holding.
                if (size_q == SZ_LOAD) begin
                    state_d = IDLE;
                end else begin
                    merged_d = merge_word;
                    state_d  = WR;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and latched fields; reset abandons any access in flight
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            last_gnt_q <= DMA;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            merged_q   <= merged_d;
        end
    end

    // Completion flags decode from the state; only the granted requester sees them
    always_comb begin
        rdata_vld   = (state_q == WAIT) && (size_q == SZ_LOAD);
        ack         = rdata_vld || (state_q == WR) || (state_q == ERR);
        err         = (state_q == ERR);

        bus.c_ack   = ack && (last_gnt_q == CPU);
        bus.d_ack   = ack && (last_gnt_q == DMA);
        bus.c_err   = err && (last_gnt_q == CPU);
        bus.d_err   = err && (last_gnt_q == DMA);
        bus.c_rdata = (rdata_vld && (last_gnt_q == CPU)) ? bus.m_rdata : '0;
        bus.d_rdata = (rdata_vld && (last_gnt_q == DMA)) ? bus.m_rdata : '0;
    end

    // Memory strobes follow the state; address and data always come from the latch
    always_comb begin
        bus.m_en    = (state_q == RD) || (state_q == WR);
        bus.m_we    = (state_q == WR);
        bus.m_addr  = addr_q[ADDR_W+1:2];
        bus.m_wdata = (size_q == SZ_WORD) ? wdata_q : merged_q;
    end

endmodule
